// File: rtl/rom_arb_pkg.sv
// Shared defaults and FSM state encoding for the two-requester ROM arbiter.
package rom_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_READ = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way arbiter: a lone requester always wins, a tie goes to the one not served last.
module rr_arbiter_2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // One-hot grant; last_grant holds the id of the requester served most recently
    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            if (last_grant) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two read requesters onto one combinational ROM (IDLE -> READ -> RESP).
// Define ROM_ARB_RR_EN for round-robin tie-break; otherwise requester 0 wins every tie.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              resp0_valid,
    output logic              resp1_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_read_enable,
    output logic              rom_chip_enable,
    input  logic [DATA_W-1:0] rom_data_out
);

    state_t      state_r;
    logic        gnt_id_r;
    logic        last_served_s;
    logic [1:0]  grant_s;
    logic        idle_s;
    logic        accept_s;

`ifdef ROM_ARB_RR_EN
    logic last_served_r;

    // Remember who finished last; reset favours requester 0 on the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_served_r <= 1'b1;
        end else if ((state_r == ST_RESP) && resp_ready) begin
            last_served_r <= gnt_id_r;
        end else begin
            last_served_r <= last_served_r;
        end
    end

    assign last_served_s = last_served_r;
`else
    assign last_served_s = 1'b1;
`endif

    rr_arbiter_2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_served_s),
        .grant      (grant_s)
    );

    // Ready is only offered in IDLE, and never while reset is held
    assign idle_s     = (state_r == ST_IDLE) && !rst;
    assign req0_ready = idle_s && grant_s[0];
    assign req1_ready = idle_s && grant_s[1];
    assign accept_s   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Transaction FSM; rom_address doubles as the latched request address
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            gnt_id_r        <= 1'b0;
            rom_address     <= '0;
            rom_chip_enable <= 1'b0;
            rom_read_enable <= 1'b0;
            resp_data       <= '0;
            resp0_valid     <= 1'b0;
            resp1_valid     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r         <= ST_READ;
                        gnt_id_r        <= grant_s[1];
                        rom_address     <= grant_s[1] ? req1_addr : req0_addr;
                        rom_chip_enable <= 1'b1;
                        rom_read_enable <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    state_r         <= ST_RESP;
                    resp_data       <= rom_data_out;
                    rom_chip_enable <= 1'b0;
                    rom_read_enable <= 1'b0;
                    resp0_valid     <= !gnt_id_r;
                    resp1_valid     <= gnt_id_r;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_r     <= ST_IDLE;
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    rom_chip_enable <= 1'b0;
                    rom_read_enable <= 1'b0;
                    resp0_valid     <= 1'b0;
                    resp1_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter plus directed literal scenarios.
module tb_rom_arbiter;

`ifdef ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_addr, req1_addr;
    logic       req0_ready, req1_ready;
    logic       resp0_valid, resp1_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic [3:0] rom_address;
    logic       rom_read_enable, rom_chip_enable;
    logic [7:0] rom_data_out;

    int n_err;
    int n_checks;

    // Model state: one outstanding transaction described by its age in cycles
    bit         m_known;
    bit         m_busy;
    int         m_age;
    bit         m_id;
    logic [3:0] m_addr;
    logic [3:0] m_rom_addr;
    logic [7:0] m_data;
    bit         m_last;

    int         q_id[$];
    logic [7:0] q_data[$];
    bit         saw0;

    rom_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0_valid      (req0_valid),
        .req0_addr       (req0_addr),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_addr       (req1_addr),
        .req1_ready      (req1_ready),
        .resp0_valid     (resp0_valid),
        .resp1_valid     (resp1_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .rom_address     (rom_address),
        .rom_read_enable (rom_read_enable),
        .rom_chip_enable (rom_chip_enable),
        .rom_data_out    (rom_data_out)
    );

    assign rom_data_out = {4'h0, rom_address} * 8'h11;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        if (rst || m_busy) return -1;
        if (req0_valid && req1_valid) return (RR && !m_last) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    // Mid-cycle: compare every DUT output against the model
    task automatic settle();
        int w;
        @(negedge clk);
        if (m_known) begin
            w = pick();
            check1("req0_ready", req0_ready, w == 0);
            check1("req1_ready", req1_ready, w == 1);
            check1("rom_chip_enable", rom_chip_enable, m_busy && m_age == 1);
            check1("rom_read_enable", rom_read_enable, m_busy && m_age == 1);
            check8("rom_address", {4'h0, rom_address}, {4'h0, m_rom_addr});
            check1("resp0_valid", resp0_valid, m_busy && m_age >= 2 && !m_id);
            check1("resp1_valid", resp1_valid, m_busy && m_age >= 2 && m_id);
            check8("resp_data", resp_data, m_data);
        end
        if ((resp0_valid || resp1_valid) && resp_ready) begin
            q_id.push_back(resp1_valid ? 1 : 0);
            q_data.push_back(resp_data);
        end
        if (resp0_valid) saw0 = 1'b1;
    endtask

    // Clock edge: advance the model using the inputs present at the edge
    task automatic advance();
        int w;
        @(posedge clk);
        w = pick();
        if (rst) begin
            m_known = 1'b1;
            m_busy = 1'b0;
            m_age = 0;
            m_rom_addr = 4'h0;
            m_data = 8'h00;
            m_last = 1'b1;
        end else if (w >= 0) begin
            m_busy = 1'b1;
            m_age = 1;
            m_id = (w == 1);
            m_addr = (w == 1) ? req1_addr : req0_addr;
            m_rom_addr = m_addr;
        end else if (m_busy && m_age == 1) begin
            m_data = {4'h0, m_addr} * 8'h11;
            m_age = 2;
        end else if (m_busy && resp_ready) begin
            m_busy = 1'b0;
            m_last = m_id;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        settle();
        advance();
        rst = 1'b0;
    endtask

    initial begin
        n_err = 0;
        n_checks = 0;
        m_known = 1'b0;
        m_busy = 1'b0;
        m_age = 0;
        m_id = 1'b0;
        m_addr = 4'h0;
        m_rom_addr = 4'h0;
        m_data = 8'h00;
        m_last = 1'b1;
        saw0 = 1'b0;
        req0_addr = 4'h0;
        req1_addr = 4'h0;
        do_reset();

        // Reset state
        settle();
        check1("rst_resp0", resp0_valid, 1'b0);
        check1("rst_resp1", resp1_valid, 1'b0);
        check8("rst_data", resp_data, 8'h00);
        check8("rst_addr", {4'h0, rom_address}, 8'h00);
        check1("rst_ce", rom_chip_enable, 1'b0);
        advance();

        // Single read of address 3 on requester 0
        req0_valid = 1'b1;
        req0_addr = 4'd3;
        settle();
        check1("t030_ready0", req0_ready, 1'b1);
        advance();
        req0_valid = 1'b0;
        req0_addr = 4'd9;
        settle();
        check1("t030_ce", rom_chip_enable, 1'b1);
        check1("t030_re", rom_read_enable, 1'b1);
        check8("t030_addr", {4'h0, rom_address}, 8'h03);
        advance();
        resp_ready = 1'b1;
        settle();
        check1("t030_resp0", resp0_valid, 1'b1);
        check8("t030_data", resp_data, 8'h33);
        advance();

        // Both requesters hammering: alternation with RR, requester 0 only without
        do_reset();
        q_id.delete();
        q_data.delete();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_addr = 4'd1;
        req1_addr = 4'd2;
        resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            settle();
            advance();
        end
        check1("t031_count", q_id.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < q_id.size()) begin
                check8("t031_id", 8'(q_id[i]), RR ? 8'(i % 2) : 8'h00);
                check8("t031_data", q_data[i], (RR && (i % 2 == 1)) ? 8'h22 : 8'h11);
            end
        end

        // Response stall on requester 1 with competing requests pending
        do_reset();
        req1_valid = 1'b1;
        req1_addr = 4'd5;
        resp_ready = 1'b0;
        settle();
        check1("t032_accept", req1_ready, 1'b1);
        advance();
        req0_valid = 1'b1;
        settle();
        advance();
        for (int i = 0; i < 5; i++) begin
            settle();
            check1("t032_resp1", resp1_valid, 1'b1);
            check8("t032_data", resp_data, 8'h55);
            check1("t032_ready0", req0_ready, 1'b0);
            check1("t032_ready1", req1_ready, 1'b0);
            check1("t032_ce", rom_chip_enable, 1'b0);
            advance();
        end
        resp_ready = 1'b1;
        settle();
        advance();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
        advance();

        // Reset asserted while the ROM read is in progress
        do_reset();
        req0_valid = 1'b1;
        req0_addr = 4'd7;
        resp_ready = 1'b1;
        settle();
        advance();
        req0_valid = 1'b0;
        rst = 1'b1;
        settle();
        check1("t033_in_read", rom_chip_enable, 1'b1);
        advance();
        rst = 1'b0;
        settle();
        check1("t033_resp0", resp0_valid, 1'b0);
        check8("t033_data", resp_data, 8'h00);
        check8("t033_addr", {4'h0, rom_address}, 8'h00);
        check1("t033_ce", rom_chip_enable, 1'b0);
        check1("t033_re", rom_read_enable, 1'b0);
        advance();
        settle();
        check1("t033_no_pulse", resp0_valid, 1'b0);
        advance();

        // Back-to-back requester 1 reads at the address extremes
        do_reset();
        q_id.delete();
        q_data.delete();
        saw0 = 1'b0;
        req1_valid = 1'b1;
        req1_addr = 4'd15;
        resp_ready = 1'b1;
        settle();
        advance();
        req1_addr = 4'd0;
        for (int i = 0; i < 5; i++) begin
            settle();
            advance();
        end
        req1_valid = 1'b0;
        check1("t034_count", q_id.size() >= 2, 1'b1);
        if (q_id.size() >= 2) begin
            check8("t034_first", q_data[0], 8'hFF);
            check8("t034_second", q_data[1], 8'h00);
            check8("t034_id", 8'(q_id[1]), 8'h01);
        end
        check1("t034_no_resp0", saw0, 1'b0);

        // Randomised traffic checked against the model every cycle
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            req0_valid = $urandom_range(0, 1) == 1;
            req1_valid = $urandom_range(0, 1) == 1;
            req0_addr = 4'($urandom_range(0, 15));
            req1_addr = 4'($urandom_range(0, 15));
            resp_ready = $urandom_range(0, 3) != 0;
            settle();
            advance();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
